mem_slot_arbiter: RTL

//  Shares one SDRAM port between CPU, video fetch and floppy DMA on the 64 MHz system clock.

---
 rtl/pcw_mem_pkg.sv | 23 ++
 rtl/mem_slot_arbiter_rr_pick.sv | 47 ++++
 rtl/mem_slot_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pcw_mem_pkg.sv
// Purpose : shared types and constants for the SDRAM slot arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: state_t (arbiter FSM states), requester index constants,
//           requester index width for the default three-requester build.
package pcw_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_VID = 1;
    localparam int REQ_FDC = 2;

    localparam int NUM_REQ_DEF = 3;
    localparam int REQ_IDX_W   = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/mem_slot_arbiter_rr_pick.sv
// Purpose : combinational winner select: urgent requesters first (lowest index),
//           otherwise round-robin starting just after last_grant.
// Latency : combinational, 0 clk.  Backpr.: none, pure function of its inputs.
//
// Ports: req/prio  per-requester request and urgent flags
//        last_grant index granted most recently (round-robin pointer)
//        valid      any request present;  grant  winning index (0 when !valid)
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] prio,
    input  logic [IW-1:0]      last_grant,
    output logic               valid,
    output logic [IW-1:0]      grant
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        valid = |req;
        grant = '0;
        found = 1'b0;
        idx   = last_grant;

        // Urgent pass: lowest index among req & prio.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && prio[i]) begin
                grant = IW'(i);
                found = 1'b1;
            end
        end

        // Round-robin pass. The wrap is explicit so NUM_REQ need not be a
        // power of two; >= also recovers from an out-of-range pointer.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx >= IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Purpose : shares one SDRAM port between CPU, video and FDC DMA; one grant per slot strobe.
// Latency : strobe at T -> mem_req at T+1 -> mem_done at T+k -> ack/rdata at T+k+1.
// Backpr. : requesters hold req until ack; strobes arriving while busy are dropped (overrun if in WAIT).
//
// Ports: clk, reset (async, active-high); slot_stb slot start pulse;
//        req/prio/we/addr/wdata per-requester command (addr/wdata packed, requester i at [i*W +: W]);
//        ack one-hot completion pulse, rdata read data valid with ack;
//        mem_req/mem_we/mem_addr/mem_wdata command to SDRAM controller, mem_done/mem_rdata its reply;
//        overrun sticky flag: slot strobe seen while waiting on the controller.
module mem_slot_arbiter import pcw_mem_pkg::*; #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 21,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slot_stb,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    prio,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic                  mem_done,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  overrun
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          start;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req        (req),
        .prio       (prio),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .grant      (pick_idx)
    );

    // A slot is only taken when idle; strobes in any other state are lost.
    assign start = (state == IDLE) && slot_stb && pick_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        ack       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // mem_done here is ignored: the controller cannot finish in the command cycle.
                mem_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    ack[i] = (grant_q == IW'(i));
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command is latched from the winner when the slot is taken, so requester
    // inputs may change freely while the access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            overrun    <= 1'b0;
        end else begin
            if (start) begin
                grant_q   <= pick_idx;
                mem_we    <= we[pick_idx];
                mem_addr  <= addr[pick_idx*AW +: AW];
                mem_wdata <= wdata[pick_idx*DW +: DW];
            end
            if ((state == WAIT) && mem_done) begin
                rdata <= mem_rdata;
            end
            if (state == DONE) begin
                // Pointer only moves once the access has really completed.
                last_grant <= grant_q;
                mem_we     <= 1'b0;
            end
            if ((state == WAIT) && slot_stb) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
